data_sram_arbiter: RTL and testbench

//  Shares the single-port data SRAM between the BNN instruction controller (core port,

---
 rtl/data_sram_arbiter.sv | 102 ++++++++++
 tb/tb_data_sram_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_arbiter.sv
// data_sram_arbiter: shares the single-port data SRAM between the core port and a host burst port
module data_sram_arbiter #(
    parameter int ADDR_W    = 13,
    parameter int DATA_W    = 16,
    parameter int LEN_W     = 8,
    parameter int MAX_BURST = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_cen,
    input  logic              core_wen,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_stall,
    output logic              core_rvalid,
    input  logic              host_start,
    input  logic [ADDR_W-1:0] host_base,
    input  logic [LEN_W-1:0]  host_len,
    input  logic              host_wr,
    input  logic              host_wvalid,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_wready,
    output logic              host_rvalid,
    output logic              host_busy,
    output logic              host_done,
    output logic [DATA_W-1:0] rdata,
    output logic              sram_cen,
    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_d,
    input  logic [DATA_W-1:0] sram_q
);
    localparam int SW = $clog2(MAX_BURST + 1);
    typedef enum logic [1:0] {IDLE, HOST, YIELD} state_t;
    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_base, w_host_addr;
    logic [LEN_W-1:0]  r_len, r_beat;
    logic              r_wr, r_core_rv, r_host_rv, r_done;
    logic [SW-1:0]     r_starve, w_starve;
    logic              w_core_gnt, w_host_go, w_last, w_starve_hit, w_start_ok, w_start_nil;
    assign w_host_addr = r_base + ADDR_W'(r_beat);
    assign w_core_gnt  = !rst && !core_cen && r_state != HOST;
    assign w_host_go   = !rst && r_state == HOST && (r_wr ? host_wvalid : 1'b1);
    assign w_last      = w_host_go && r_beat == r_len - LEN_W'(1);
    assign w_start_ok  = r_state == IDLE && host_start && host_len != '0;
    assign w_start_nil = r_state == IDLE && host_start && host_len == '0;
    assign core_stall  = !core_cen && r_state == HOST;
    assign core_rvalid = r_core_rv;
    assign host_rvalid = r_host_rv;
    assign host_wready = r_state == HOST && r_wr;
    assign host_busy   = r_state != IDLE;
    assign host_done   = r_done;
    assign rdata       = (r_core_rv || r_host_rv) ? sram_q : '0;
    assign sram_cen    = !(w_core_gnt || w_host_go);
    assign sram_wen    = w_core_gnt ? core_wen : w_host_go ? !r_wr : 1'b1;
    assign sram_addr   = w_core_gnt ? core_addr : w_host_go ? w_host_addr : '0;
    assign sram_d      = w_core_gnt ? core_wdata : (w_host_go && r_wr) ? host_wdata : '0;
    // next state: finishing a burst beats a pending forced core slot
    always_comb begin
        w_starve     = (r_state == HOST && !core_cen) ? r_starve + SW'(1) : '0;
        w_starve_hit = w_starve == SW'(MAX_BURST);
        w_next       = r_state;
        if (w_start_ok)
            w_next = HOST;
        else if (r_state == YIELD)
            w_next = HOST;
        else if (r_state == HOST)
            w_next = w_last ? IDLE : w_starve_hit ? YIELD : HOST;
    end
    // state, starvation counter and read-owner tags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_starve  <= '0;
            r_core_rv <= 1'b0;
            r_host_rv <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_starve  <= w_starve_hit ? '0 : w_starve;
            r_core_rv <= w_core_gnt && core_wen;
            r_host_rv <= w_host_go && !r_wr;
            r_done    <= w_last || w_start_nil;
        end
    end
    // burst descriptor latched on start, beat advances on each issued host access
    always_ff @(posedge clk) begin
        if (rst) begin
            r_base <= '0;
            r_len  <= '0;
            r_wr   <= 1'b0;
            r_beat <= '0;
        end else if (r_state == IDLE && host_start) begin
            r_base <= host_base;
            r_len  <= host_len;
            r_wr   <= host_wr;
            r_beat <= '0;
        end else if (w_host_go) begin
            r_beat <= r_beat + LEN_W'(1);
        end
    end
endmodule

// File: tb/tb_data_sram_arbiter.sv
// tb_data_sram_arbiter: directed and randomized bench checked against a burst-level behavioural model
`timescale 1ns/1ps
module tb_data_sram_arbiter;
    localparam int AW = 13, DW = 16, LW = 8, MB = 4;
    logic          clk = 1'b0, rst = 1'b1;
    logic          core_cen = 1'b1, core_wen = 1'b1;
    logic [AW-1:0] core_addr = '0;
    logic [DW-1:0] core_wdata = '0;
    logic          host_start = 1'b0, host_wr = 1'b0, host_wvalid = 1'b0;
    logic [AW-1:0] host_base = '0;
    logic [LW-1:0] host_len = '0;
    logic [DW-1:0] host_wdata = '0;
    logic          core_stall, core_rvalid, host_wready, host_rvalid, host_busy, host_done;
    logic          sram_cen, sram_wen;
    logic [DW-1:0] rdata, sram_d;
    logic [DW-1:0] sram_q = '0;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] mem [1<<AW];
    logic [DW-1:0] ref_mem [1<<AW];
    int            n_vec = 0, n_err = 0;
    bit            chk_on = 1'b0;
    bit            m_busy, m_yield, m_wr, m_crv, m_hrv, m_done;
    int            m_base, m_len, m_issued, m_wait;
    logic [DW-1:0] m_rd = '0;

    data_sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .core_cen(core_cen), .core_wen(core_wen), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_stall(core_stall), .core_rvalid(core_rvalid),
        .host_start(host_start), .host_base(host_base), .host_len(host_len), .host_wr(host_wr),
        .host_wvalid(host_wvalid), .host_wdata(host_wdata), .host_wready(host_wready),
        .host_rvalid(host_rvalid), .host_busy(host_busy), .host_done(host_done),
        .rdata(rdata), .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_addr(sram_addr),
        .sram_d(sram_d), .sram_q(sram_q)
    );

    always #5 clk = ~clk;

    // single-port SRAM with one cycle read latency
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_wen) mem[sram_addr] <= sram_d;
            else sram_q <= mem[sram_addr];
        end
    end

    function automatic logic [DW-1:0] seed(input int a);
        return DW'(a * 7 + 'h3C5A);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // model: who owns the SRAM this cycle, what each output must be, then advance the burst bookkeeping
    always @(negedge clk) begin
        bit            g_core, h_act, e_cen, e_wen;
        int            e_addr;
        logic [DW-1:0] e_d;
        g_core = !rst && !core_cen && !(m_busy && !m_yield);
        h_act  = !rst && m_busy && !m_yield && (m_wr ? host_wvalid : 1'b1);
        e_cen  = !(g_core || h_act);
        e_addr = g_core ? int'(core_addr) : h_act ? (m_base + m_issued) % (1 << AW) : 0;
        e_wen  = g_core ? core_wen : h_act ? !m_wr : 1'b1;
        e_d    = g_core ? core_wdata : (h_act && m_wr) ? host_wdata : '0;
        if (chk_on) begin
            chk("core_stall", 32'(core_stall), 32'(!core_cen && m_busy && !m_yield));
            chk("core_rvalid", 32'(core_rvalid), 32'(m_crv));
            chk("host_rvalid", 32'(host_rvalid), 32'(m_hrv));
            chk("host_wready", 32'(host_wready), 32'(m_busy && !m_yield && m_wr));
            chk("host_busy", 32'(host_busy), 32'(m_busy));
            chk("host_done", 32'(host_done), 32'(m_done));
            chk("rdata", 32'(rdata), (m_crv || m_hrv) ? 32'(m_rd) : 32'd0);
            chk("sram_cen", 32'(sram_cen), 32'(e_cen));
            chk("sram_wen", 32'(sram_wen), 32'(e_wen));
            chk("sram_addr", 32'(sram_addr), 32'(e_addr));
            if (e_cen || !e_wen) chk("sram_d", 32'(sram_d), 32'(e_d));
        end
        if (rst) begin
            {m_busy, m_yield, m_wr, m_crv, m_hrv, m_done} = '0;
            m_issued = 0;
            m_wait = 0;
        end else begin
            m_crv  = g_core && core_wen;
            m_hrv  = h_act && !m_wr;
            m_done = 1'b0;
            if (!e_cen) begin
                if (e_wen) m_rd = ref_mem[e_addr];
                else ref_mem[e_addr] = e_d;
            end
            if (!m_busy) begin
                if (host_start && host_len == 0) m_done = 1'b1;
                else if (host_start) begin
                    m_busy = 1'b1;
                    m_yield = 1'b0;
                    m_base = int'(host_base);
                    m_len = int'(host_len);
                    m_wr = host_wr;
                    m_issued = 0;
                    m_wait = 0;
                end
            end else if (m_yield) begin
                m_yield = 1'b0;
            end else begin
                if (h_act) m_issued++;
                if (m_issued == m_len) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end else begin
                    m_wait = core_cen ? 0 : m_wait + 1;
                    if (m_wait == MB) begin
                        m_yield = 1'b1;
                        m_wait = 0;
                    end
                end
            end
        end
    end

    initial begin
        logic [AW-1:0] wa [4];
        int beats, yields, first_y;
        bit seen_done;
        wa = '{13'h1FFE, 13'h1FFF, 13'h0000, 13'h0001};
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i] = seed(i);
            ref_mem[i] = seed(i);
        end
        step();
        chk_on = 1'b1;
        step();
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_sram_cen", 32'(sram_cen), 32'd1);
        chk("rst_busy", 32'(host_busy), 32'd0);
        chk("rst_core_rvalid", 32'(core_rvalid), 32'd0);
        rst = 1'b0;
        // core-only read
        core_cen = 1'b0; core_wen = 1'b1; core_addr = 13'h0123;
        #1;
        chk("core_rd_cen", 32'(sram_cen), 32'd0);
        chk("core_rd_wen", 32'(sram_wen), 32'd1);
        chk("core_rd_addr", 32'(sram_addr), 32'h0123);
        step();
        core_cen = 1'b1;
        #1;
        chk("core_rd_rvalid", 32'(core_rvalid), 32'd1);
        chk("core_rd_data", 32'(rdata), 32'(seed('h123)));
        // host write burst wrapping the top of the address space
        host_start = 1'b1; host_len = 8'd4; host_base = 13'h1FFE; host_wr = 1'b1; host_wvalid = 1'b1;
        step();
        host_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            host_wdata = 16'hB000 + 16'(i);
            #1;
            chk("hw_addr", 32'(sram_addr), 32'(wa[i]));
            chk("hw_wen", 32'(sram_wen), 32'd0);
            step();
        end
        #1;
        chk("hw_done", 32'(host_done), 32'd1);
        host_wvalid = 1'b0;
        // zero-length burst
        step();
        host_start = 1'b1; host_len = 8'd0;
        #1;
        chk("len0_cen", 32'(sram_cen), 32'd1);
        step();
        host_start = 1'b0;
        #1;
        chk("len0_done", 32'(host_done), 32'd1);
        chk("len0_busy", 32'(host_busy), 32'd0);
        // read burst with core stalled and a start ignored while busy
        step();
        host_start = 1'b1; host_len = 8'd3; host_base = 13'h0040; host_wr = 1'b0;
        step();
        host_base = 13'h0100; host_len = 8'd5;
        #1;
        chk("hr_addr0", 32'(sram_addr), 32'h0040);
        step();
        host_start = 1'b0; core_cen = 1'b0; core_wen = 1'b1; core_addr = 13'h0200;
        #1;
        chk("hr_stall1", 32'(core_stall), 32'd1);
        chk("hr_addr1", 32'(sram_addr), 32'h0041);
        chk("hr_rvalid0", 32'(host_rvalid), 32'd1);
        step();
        #1;
        chk("hr_stall2", 32'(core_stall), 32'd1);
        chk("hr_addr2", 32'(sram_addr), 32'h0042);
        chk("hr_rvalid1", 32'(host_rvalid), 32'd1);
        step();
        #1;
        chk("hr_stall_end", 32'(core_stall), 32'd0);
        chk("hr_done", 32'(host_done), 32'd1);
        chk("hr_rvalid2", 32'(host_rvalid), 32'd1);
        chk("hr_core_addr", 32'(sram_addr), 32'h0200);
        step();
        core_cen = 1'b1;
        #1;
        chk("hr_core_rvalid", 32'(core_rvalid), 32'd1);
        chk("hr_ignored_start", 32'(host_busy), 32'd0);
        // forced yield while the core keeps requesting
        step();
        core_cen = 1'b0; core_wen = 1'b1; core_addr = 13'h0300;
        host_start = 1'b1; host_len = 8'd10; host_base = 13'h0500; host_wr = 1'b1; host_wvalid = 1'b1;
        step();
        host_start = 1'b0;
        beats = 0; yields = 0; first_y = -1; seen_done = 1'b0;
        for (int c = 0; c < 40 && !seen_done; c++) begin
            #1;
            if (host_done) seen_done = 1'b1;
            else begin
                if (host_wready && host_wvalid) beats++;
                if (host_busy && !core_stall) begin
                    yields++;
                    if (first_y < 0) first_y = beats;
                end
            end
            step();
        end
        chk("yield_done_seen", 32'(seen_done), 32'd1);
        chk("yield_beats", 32'(beats), 32'd10);
        chk("yield_slots", 32'(yields), 32'd2);
        chk("yield_first", 32'(first_y), 32'd4);
        core_cen = 1'b1; host_wvalid = 1'b0;
        // reset in the middle of a read burst
        step();
        host_start = 1'b1; host_len = 8'd8; host_base = 13'h0600; host_wr = 1'b0;
        step();
        host_start = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("abort_stall", 32'(core_stall), 32'd0);
        chk("abort_core_rvalid", 32'(core_rvalid), 32'd0);
        chk("abort_host_rvalid", 32'(host_rvalid), 32'd0);
        chk("abort_busy", 32'(host_busy), 32'd0);
        chk("abort_done", 32'(host_done), 32'd0);
        chk("abort_rdata", 32'(rdata), 32'd0);
        chk("abort_cen", 32'(sram_cen), 32'd1);
        chk("abort_wready", 32'(host_wready), 32'd0);
        for (int c = 0; c < 5; c++) begin
            step();
            chk("abort_no_done", 32'(host_done), 32'd0);
        end
        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            step();
            rst = $urandom_range(0, 399) == 0;
            core_cen = $urandom_range(0, 2) == 0;
            core_wen = 1'($urandom);
            core_addr = AW'($urandom);
            core_wdata = DW'($urandom);
            host_start = $urandom_range(0, 11) == 0;
            host_len = LW'($urandom_range(0, 12));
            host_base = ($urandom_range(0, 3) == 0) ? AW'(13'h1FF8 + 13'($urandom_range(0, 7))) : AW'($urandom);
            host_wr = 1'($urandom);
            host_wvalid = $urandom_range(0, 9) < 7;
            host_wdata = DW'($urandom);
        end
        step();
        rst = 1'b0; core_cen = 1'b1; host_start = 1'b0;
        repeat (20) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
